img2col_ram_reader: RTL

- Read-side initiator for the single-port tensor RAM.
- Walks a single-channel IMG_H x IMG_W image, stored row-major from address 0, in img2col order and emits one pixel per beat on a valid/ready stream toward the GEMM feeder.
- Drives the RAM port (addr/en/we/din) and absorbs its fixed 1-cycle registered read latency with a 2-entry skid buffer. Full throughput is 1 beat/cycle when the sink is always ready.

---
 rtl/img2col_pkg.sv | 25 ++
 rtl/img2col_skid2.sv | 46 ++++
 rtl/img2col_ram_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/img2col_pkg.sv
// Shared types and geometry helpers for the img2col RAM reader.
package img2col_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Per-beat side-band tags; the pixel width is bound where DATA_WIDTH is known.
    typedef struct packed {
        logic last;
        logic frame_last;
    } beat_tag_t;

    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    function automatic int frame_total(input int h, input int w, input int k, input int s);
        return out_dim(h, k, s) * out_dim(w, k, s) * k * k;
    endfunction

endpackage

// File: rtl/img2col_skid2.sv
// Two-entry FIFO that absorbs the RAM read latency in front of the output stream.
module img2col_skid2 #(
    parameter type beat_t = logic [9:0]
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  beat_t      din,
    output beat_t      head,
    output logic [1:0] count
);

    beat_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset on purpose so the head, and thus m_data, reads 0 out of reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end

    overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !do_pop && count == 2'd2))
        else $error("img2col_skid2: push into a full buffer");

endmodule

// File: rtl/img2col_ram_reader.sv
// Walks an IMG_H x IMG_W image in img2col order (oy, ox, ky, kx) and streams one pixel per beat.
module img2col_ram_reader
    import img2col_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 10,
    parameter int IMG_H      = 4,
    parameter int IMG_W      = 4,
    parameter int K          = 3,
    parameter int S          = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_frame_last
);

    if (IMG_H * IMG_W > 2 ** ADDR_SIZE || K > IMG_H || K > IMG_W || S < 1) begin : g_param_check
        $error("img2col_ram_reader: illegal geometry parameters");
    end

    localparam int unsigned K_LAST  = K - 1;
    localparam int unsigned OX_LAST = out_dim(IMG_W, K, S) - 1;
    localparam int unsigned OY_LAST = out_dim(IMG_H, K, S) - 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        beat_tag_t             tag;
    } beat_t;

    state_t      state;
    int unsigned oy, ox, ky, kx;
    logic        inflight;
    beat_tag_t   tag_q;
    beat_tag_t   issue_tag;
    beat_t       push_beat;
    beat_t       head;
    logic [1:0]  count;
    logic [2:0]  occupancy;
    logic        pop;
    logic        issue;

    // A slot is claimed at issue time, so entries plus the read in flight never exceed two.
    assign pop       = m_valid && m_ready;
    assign occupancy = {1'b0, count} + {2'b0, inflight};
    assign issue     = (state == RUN) && (occupancy < 3'd2 + {2'b0, pop});

    assign issue_tag.last       = (ky == K_LAST) && (kx == K_LAST);
    assign issue_tag.frame_last = issue_tag.last && (ox == OX_LAST) && (oy == OY_LAST);

    assign ram_en   = issue;
    assign ram_addr = ADDR_SIZE'((oy * S + ky) * IMG_W + ox * S + kx);
    assign ram_we   = 1'b0;
    assign ram_din  = '0;

    assign push_beat.data = ram_dout;
    assign push_beat.tag  = tag_q;

    img2col_skid2 #(
        .beat_t (beat_t)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   (push_beat),
        .head  (head),
        .count (count)
    );

    assign m_valid      = (count != 2'd0);
    assign m_data       = head.data;
    assign m_last       = head.tag.last;
    assign m_frame_last = head.tag.frame_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            oy       <= 0;
            ox       <= 0;
            ky       <= 0;
            kx       <= 0;
            inflight <= 1'b0;
            tag_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees the pre-edge counter values.
            inflight <= issue;
            done     <= 1'b0;
            if (issue) begin
                tag_q <= issue_tag;
                if (kx == K_LAST) begin
                    kx <= 0;
                    if (ky == K_LAST) begin
                        ky <= 0;
                        if (ox == OX_LAST) begin
                            ox <= 0;
                            oy <= (oy == OY_LAST) ? 0 : oy + 1;
                        end else begin
                            ox <= ox + 1;
                        end
                    end else begin
                        ky <= ky + 1;
                    end
                end else begin
                    kx <= kx + 1;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        oy    <= 0;
                        ox    <= 0;
                        ky    <= 0;
                        kx    <= 0;
                    end
                end
                RUN: begin
                    if (issue && issue_tag.frame_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m_frame_last && count == 2'd1 && !inflight) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
